// File: rtl/or_reduce_seq_if.sv
// Handshake bundle for or_reduce_seq: word/mode in, reduction result out.
// master = producer/consumer side, slave = the reduction unit.
interface or_reduce_seq_if #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out;
    logic             found;
    logic [IDXW-1:0]  first_idx;

    modport master (
        output in_valid, in_word, in_mode, out_ready,
        input  in_ready, out_valid, out, found, first_idx
    );

    modport slave (
        input  in_valid, in_word, in_mode, out_ready,
        output in_ready, out_valid, out, found, first_idx
    );
endinterface

// File: rtl/or_reduce_seq.sv
// Multi-cycle OR/AND/XOR/NOR reduction of a WIDTH-bit word, CHUNK bits per cycle,
// plus lowest-set-bit index. All outputs registered.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for in_valid
// RUN    | folding one chunk per cycle, cnt = chunk number
// DONE   | out_valid=1, result held until out_ready
module or_reduce_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int IDXW  = 6
) (
    input logic          clk,
    input logic          reset,
    or_reduce_seq_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(NCH - 1);
    localparam logic [IDXW-1:0] CHUNK_I  = IDXW'(CHUNK);

    localparam logic [1:0] M_OR  = 2'b00;
    localparam logic [1:0] M_AND = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;
    localparam logic [1:0] M_NOR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [1:0]       mode_q, mode_d;
    logic             acc_q, acc_d;
    logic             fnd_q, fnd_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDXW-1:0]  base_q, base_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_q, out_d;
    logic             found_q, found_d;
    logic [IDXW-1:0]  first_idx_q, first_idx_d;

    logic [CHUNK-1:0] chunk;
    logic [IDXW-1:0]  lsb_pos;
    logic             acc_fold;

    // The captured word is shifted down each pass, so the current chunk is always the low bits.
    assign chunk = word_q[CHUNK-1:0];

    always_comb begin
        lsb_pos = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) lsb_pos = IDXW'(i);
        end
    end

    always_comb begin
        acc_fold = acc_q;
        case (mode_q)
            M_OR, M_NOR: acc_fold = acc_q | (|chunk);
            M_AND:       acc_fold = acc_q & (&chunk);
            M_XOR:       acc_fold = acc_q ^ (^chunk);
            default:     acc_fold = acc_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        fnd_d       = fnd_q;
        idx_d       = idx_q;
        base_d      = base_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        found_d     = found_q;
        first_idx_d = first_idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d    = S_RUN;
                    word_d     = bus.in_word;
                    mode_d     = bus.in_mode;
                    cnt_d      = '0;
                    base_d     = '0;
                    acc_d      = (bus.in_mode == M_AND);
                    fnd_d      = 1'b0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            S_RUN: begin
                word_d = word_q >> CHUNK;
                acc_d  = acc_fold;
                if (!fnd_q && (|chunk)) begin
                    fnd_d = 1'b1;
                    idx_d = base_q + lsb_pos;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    out_d       = (mode_q == M_NOR) ? ~acc_fold : acc_fold;
                    found_d     = fnd_d;
                    first_idx_d = idx_d;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    base_d = base_q + CHUNK_I;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            mode_q      <= '0;
            acc_q       <= 1'b0;
            fnd_q       <= 1'b0;
            idx_q       <= '0;
            base_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            found_q     <= 1'b0;
            first_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            fnd_q       <= fnd_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            found_q     <= found_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.found     = found_q;
    assign bus.first_idx = first_idx_q;
endmodule
